// File: rtl/chip8_ps2_keypad.sv
// chip8_ps2_keypad
// PS/2 receiver plus scan-code set 2 decoder that drives the 16-key CHIP-8
// hex keypad state. Everything runs in the clk_sys domain.
// Optional build macro: CHIP8_PS2_PARITY_CHECK_EN enables odd-parity checking.
// When it is undefined, the parity bit is still captured but not checked.

module chip8_ps2_keypad #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   output logic [15:0] keys,
   output logic        key_any,
   output logic [3:0]  key_last,
   output logic        key_event,
   output logic [7:0]  rx_byte,
   output logic        rx_strobe,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frameState_t;

   frameState_t r_state, w_nextState;

   logic [1:0]    r_clkSync, r_datSync;
   logic          r_clkPrev;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitCount;
   logic          r_parityBit;
   logic [TW-1:0] r_timeoutCnt;
   logic          r_ext, r_brk;

   logic          w_fall, w_sample, w_timeout, w_parityGood, w_parityOk;
   logic          w_strobe, w_err;
   logic          w_mapped;
   logic [3:0]    w_keyIdx;

   // Two-flop synchronisers on both PS/2 lines, plus the previous-clock register for edge detection
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_clkSync <= 2'b11;
         r_datSync <= 2'b11;
         r_clkPrev <= 1'b1;
      end else begin
         r_clkSync <= {r_clkSync[0], ps2_clk};
         r_datSync <= {r_datSync[0], ps2_dat};
         r_clkPrev <= r_clkSync[1];
      end
   end

   assign w_fall       = r_clkPrev & ~r_clkSync[1];
   assign w_sample     = r_datSync[1];
   assign w_timeout    = (r_state != IDLE) && !w_fall &&
                         (r_timeoutCnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_parityGood = ^{r_shift, r_parityBit};

`ifdef CHIP8_PS2_PARITY_CHECK_EN
   assign w_parityOk = w_parityGood;
`else
   assign w_parityOk = w_parityGood | 1'b1;
`endif

   // Frame state register
   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Frame next-state logic; a falling edge always takes priority over a timeout
   always_comb begin
      w_nextState = r_state;
      w_strobe    = 1'b0;
      w_err       = 1'b0;
      if (w_fall) begin
         case (r_state)
            IDLE:    if (!w_sample) w_nextState = DATA;
            DATA:    if (r_bitCount == 3'd7) w_nextState = PARITY;
            PARITY:  w_nextState = STOP;
            STOP: begin
               w_nextState = IDLE;
               if (w_sample && w_parityOk) w_strobe = 1'b1;
               else                        w_err    = 1'b1;
            end
            default: w_nextState = IDLE;
         endcase
      end else if (w_timeout) begin
         w_nextState = IDLE;
         w_err       = 1'b1;
      end
   end

   // Frame datapath: shifter, bit counter, parity capture, timeout counter and receive outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_shift      <= 8'd0;
         r_bitCount   <= 3'd0;
         r_parityBit  <= 1'b0;
         r_timeoutCnt <= '0;
         rx_byte      <= 8'd0;
         rx_strobe    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_strobe <= w_strobe;
         frame_err <= w_err;
         if (w_strobe) rx_byte <= r_shift;
         if (w_fall) begin
            r_timeoutCnt <= '0;
            if (r_state == IDLE) r_bitCount <= 3'd0;
            if (r_state == DATA) begin
               r_shift    <= {w_sample, r_shift[7:1]};
               r_bitCount <= r_bitCount + 3'd1;
            end
            if (r_state == PARITY) r_parityBit <= w_sample;
         end else if (r_state != IDLE && !w_timeout) begin
            r_timeoutCnt <= r_timeoutCnt + TW'(1);
         end else begin
            r_timeoutCnt <= '0;
         end
      end
   end

   // Scan code set 2 to CHIP-8 hex key lookup
   always_comb begin
      w_mapped = 1'b1;
      w_keyIdx = 4'h0;
      case (rx_byte)
         8'h16: w_keyIdx = 4'h1;
         8'h1E: w_keyIdx = 4'h2;
         8'h26: w_keyIdx = 4'h3;
         8'h25: w_keyIdx = 4'hC;
         8'h15: w_keyIdx = 4'h4;
         8'h1D: w_keyIdx = 4'h5;
         8'h24: w_keyIdx = 4'h6;
         8'h2D: w_keyIdx = 4'hD;
         8'h1C: w_keyIdx = 4'h7;
         8'h1B: w_keyIdx = 4'h8;
         8'h23: w_keyIdx = 4'h9;
         8'h2B: w_keyIdx = 4'hE;
         8'h1A: w_keyIdx = 4'hA;
         8'h22: w_keyIdx = 4'h0;
         8'h21: w_keyIdx = 4'hB;
         8'h2A: w_keyIdx = 4'hF;
         default: w_mapped = 1'b0;
      endcase
   end

   // Make/break decoder: prefix flags, keypad state, and new-press event reporting
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_ext     <= 1'b0;
         r_brk     <= 1'b0;
         keys      <= 16'd0;
         key_last  <= 4'd0;
         key_event <= 1'b0;
      end else begin
         key_event <= 1'b0;
         if (rx_strobe) begin
            if (rx_byte == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               if (!r_ext && w_mapped) begin
                  if (r_brk) begin
                     keys[w_keyIdx] <= 1'b0;
                  end else begin
                     keys[w_keyIdx] <= 1'b1;
                     if (!keys[w_keyIdx]) begin
                        key_last  <= w_keyIdx;
                        key_event <= 1'b1;
                     end
                  end
               end
               r_ext <= 1'b0;
               r_brk <= 1'b0;
            end
         end
      end
   end

   assign key_any = |keys;

endmodule

// File: tb/tb_chip8_ps2_keypad.sv
// tb_chip8_ps2_keypad
// Scoreboard bench: stimulus pushes expected events (received byte, frame
// error, key press) into a queue; a monitor pops and compares whenever the
// DUT pulses rx_strobe, frame_err or key_event.

module tb_chip8_ps2_keypad;

   localparam int TIMEOUT = 300;
   localparam int HALF    = 8;

   localparam logic [3:0] EV_RX  = 4'd1;
   localparam logic [3:0] EV_ERR = 4'd2;
   localparam logic [3:0] EV_KEY = 4'd3;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic [15:0] keys;
   logic        key_any;
   logic [3:0]  key_last;
   logic        key_event;
   logic [7:0]  rx_byte;
   logic        rx_strobe;
   logic        frame_err;

   logic [23:0] expQ[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] expKeys;

   chip8_ps2_keypad #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .keys      (keys),
      .key_any   (key_any),
      .key_last  (key_last),
      .key_event (key_event),
      .rx_byte   (rx_byte),
      .rx_strobe (rx_strobe),
      .frame_err (frame_err)
   );

   // 100 MHz system clock
   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Drive the first nBits bits of a PS/2 frame (start, 8 data LSB first, parity, stop)
   task automatic applyStimulus(input logic [7:0] data, input bit badParity, input int nBits);
      logic [10:0] bits;
      logic        par;
      par  = badParity ? (^data) : ~(^data);
      bits = {1'b1, par, data, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         ps2_dat = bits[i];
         cycles(HALF);
         ps2_clk = 1'b0;
         cycles(HALF);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      cycles(2 * HALF);
   endtask

   task automatic expectRx(input logic [7:0] b);
      expQ.push_back({EV_RX, 12'h000, b});
   endtask

   task automatic expectKey(input logic [15:0] k, input logic [3:0] last);
      expQ.push_back({EV_KEY, k, last});
   endtask

   task automatic sendGood(input logic [7:0] b);
      expectRx(b);
      applyStimulus(b, 1'b0, 11);
   endtask

   // Monitor: every output event must match the head of the expected queue
   always @(negedge clk_sys) begin
      if (!reset && (rx_strobe || frame_err || key_event)) begin
         logic [23:0] got;
         logic [23:0] exp;
         if (rx_strobe)      got = {EV_RX, 12'h000, rx_byte};
         else if (frame_err) got = {EV_ERR, 20'h00000};
         else                got = {EV_KEY, keys, key_last};
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedEvent: got %h expected none", got);
         end else begin
            exp = expQ.pop_front();
            checkOutput("event", {8'h00, got}, {8'h00, exp});
         end
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cycles(4);
      reset = 1'b0;
      @(negedge clk_sys);
      checkOutput("resetKeys",    {16'h0, keys}, 32'h0);
      checkOutput("resetKeyAny",  {31'h0, key_any}, 32'h0);
      checkOutput("resetKeyLast", {28'h0, key_last}, 32'h0);
      checkOutput("resetRxByte",  {24'h0, rx_byte}, 32'h0);
      checkOutput("resetStrobe",  {31'h0, rx_strobe}, 32'h0);
      checkOutput("resetErr",     {31'h0, frame_err}, 32'h0);
      cycles(4);

      // Single make of key 5
      expectRx(8'h1D);
      expectKey(16'h0020, 4'h5);
      applyStimulus(8'h1D, 1'b0, 11);
      checkOutput("make1DKeys", {16'h0, keys}, 32'h0020);
      checkOutput("make1DAny",  {31'h0, key_any}, 32'h1);

      // Typematic repeat then break
      sendGood(8'h1D);
      sendGood(8'hF0);
      sendGood(8'h1D);
      checkOutput("breakKeys", {16'h0, keys}, 32'h0000);
      checkOutput("breakLast", {28'h0, key_last}, 32'h5);

      // Extended code ignored, then key 0 make
      sendGood(8'hE0);
      sendGood(8'h75);
      expectRx(8'h22);
      expectKey(16'h0001, 4'h0);
      applyStimulus(8'h22, 1'b0, 11);
      checkOutput("make22Keys", {16'h0, keys}, 32'h0001);

      // Release key 0, then send 0x16 with inverted parity
      sendGood(8'hF0);
      sendGood(8'h22);
`ifdef CHIP8_PS2_PARITY_CHECK_EN
      expQ.push_back({EV_ERR, 20'h00000});
      expKeys = 16'h0000;
`else
      expectRx(8'h16);
      expectKey(16'h0002, 4'h1);
      expKeys = 16'h0002;
`endif
      applyStimulus(8'h16, 1'b1, 11);
      checkOutput("badParityKeys", {16'h0, keys}, {16'h0, expKeys});

      // Partial frame abandoned by timeout, then a clean frame
      expQ.push_back({EV_ERR, 20'h00000});
      applyStimulus(8'h05, 1'b0, 4);
      cycles(TIMEOUT + 20);
      checkOutput("timeoutDrained", expQ.size(), 32'd0);
      expKeys = expKeys | 16'h8000;
      expectRx(8'h2A);
      expectKey(expKeys, 4'hF);
      applyStimulus(8'h2A, 1'b0, 11);
      checkOutput("make2AKeys", {16'h0, keys}, {16'h0, expKeys});

      // Build keys = 0x0011, then reset in the middle of a frame
      sendGood(8'hF0);
      sendGood(8'h2A);
      sendGood(8'hF0);
      sendGood(8'h16);
      expectRx(8'h22);
      expectKey(16'h0001, 4'h0);
      applyStimulus(8'h22, 1'b0, 11);
      expectRx(8'h15);
      expectKey(16'h0011, 4'h4);
      applyStimulus(8'h15, 1'b0, 11);
      checkOutput("preResetKeys", {16'h0, keys}, 32'h0011);
      applyStimulus(8'h1E, 1'b0, 5);
      @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      checkOutput("midResetKeys",    {16'h0, keys}, 32'h0);
      checkOutput("midResetAny",     {31'h0, key_any}, 32'h0);
      checkOutput("midResetLast",    {28'h0, key_last}, 32'h0);
      checkOutput("midResetEvent",   {31'h0, key_event}, 32'h0);
      checkOutput("midResetRxByte",  {24'h0, rx_byte}, 32'h0);
      checkOutput("midResetStrobe",  {31'h0, rx_strobe}, 32'h0);
      checkOutput("midResetErr",     {31'h0, frame_err}, 32'h0);
      reset = 1'b0;
      cycles(4);

      // Fresh frame after reset decodes normally
      expectRx(8'h1E);
      expectKey(16'h0004, 4'h2);
      applyStimulus(8'h1E, 1'b0, 11);
      checkOutput("postResetKeys", {16'h0, keys}, 32'h0004);

      cycles(20);
      checkOutput("queueEmpty", expQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chip8_ps2_keypad.md
# chip8_ps2_keypad

Receive side of the PS/2 keyboard stream emitted by `hps_io` (`ps2_kbd_clk_out` / `ps2_kbd_data_out`).
- Deserialises 11-bit PS/2 frames and decodes scan-code set 2 make/break sequences.
- Maintains the 16-key CHIP-8 hex keypad state consumed by the `chip8` machine (FX0A wait-for-key, EX9E/EXA1 skip instructions).
- Sits in the `emu` top level in the `clk_sys` domain, between `hps_io` and `chip8`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: `clk_sys` cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock from `hps_io`; treated as asynchronous.
- `ps2_dat`  in  1  PS/2 data from `hps_io`; treated as asynchronous.
- `keys`  out  16  keypad state; bit n = hex key n held.
- `key_any`  out  1  OR of `keys`.
- `key_last`  out  4  hex code of the most recent newly pressed key.
- `key_event`  out  1  one-cycle pulse when a mapped key goes from released to pressed.
- `rx_byte`  out  8  last received byte.
- `rx_strobe`  out  1  one-cycle pulse when `rx_byte` updates.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit, a parity error (when checked), or a timeout.

## Operation
Input synchronisation and edge detection:
- `ps2_clk` and `ps2_dat` each pass through a 2-flop synchroniser.
- A falling edge is detected on the synchronised clock (previous=1, current=0); data is sampled on that cycle.

Frame FSM, advanced one state per falling edge:
- IDLE: sampled 0 → DATA (bit count cleared); sampled 1 → stay in IDLE (glitch).
- DATA: shift data in LSB first; after the 8th bit → PARITY.
- PARITY: store the sampled bit → STOP.
- STOP: sampled 1 with parity OK → pulse `rx_strobe` and load `rx_byte`. Sampled 0 or parity bad → pulse `frame_err` and discard the byte. Either way → IDLE.
- Parity is odd: the XOR of the 8 data bits and the parity bit must equal 1.
- Timeout counter: cleared on every falling edge; increments in any non-IDLE state. On reaching `TIMEOUT_CYCLES` → IDLE and pulse `frame_err`.

Decode, acting on each `rx_strobe` byte:
- 0xE0: set `ext`.
- 0xF0: set `brk`.
- Any other byte: if `ext` is clear and the byte is a mapped code, apply a make (or a break if `brk` is set). Then clear both `ext` and `brk`.
- 0xFA, 0xAA, 0xEE and unmapped codes change only the flags, as above.

Key map, scan code → hex key:
- 0x16→1, 0x1E→2, 0x26→3, 0x25→C
- 0x15→4, 0x1D→5, 0x24→6, 0x2D→D
- 0x1C→7, 0x1B→8, 0x23→9, 0x2B→E
- 0x1A→A, 0x22→0, 0x21→B, 0x2A→F

Key state updates:
- Make: set `keys[n]`. If the bit was previously 0, also load `key_last`=n and pulse `key_event`.
- Typematic repeat of a held key: no `key_event`, no `key_last` change.
- Break: clear `keys[n]`. `key_last` is unchanged.

## Timing
- Reset (synchronous, priority over everything): all outputs 0, frame FSM in IDLE, `ext`/`brk`/timeout counter cleared, synchroniser flops set to 1.
- Sample point: the 3rd `clk_sys` edge after `ps2_clk` falls at the pin (2 synchroniser stages + edge register).
- `rx_strobe`, `rx_byte`, `frame_err`: asserted the cycle after the stop-bit sample cycle.
- `keys`, `key_event`, `key_last`: update the cycle after `rx_strobe`, i.e. 1-cycle decode latency.
- Reset mid-frame: the partial frame is lost; the next start bit begins a fresh frame.
- Timeout and a falling edge in the same cycle: the edge wins and the counter clears.
- No new byte can arrive within 2 cycles of `rx_strobe`, so decode never overlaps.

## Configuration
- `CHIP8_PS2_PARITY_CHECK_EN` defined: parity is checked; a bad parity bit causes `frame_err` and the byte is dropped.
- Undefined: the parity bit is sampled but ignored; only the stop bit and the timeout raise `frame_err`.

## Test plan
- Frame 0x1D with correct parity → `rx_byte`=0x1D, one `rx_strobe`; `keys`=0x0020, `key_last`=5, one `key_event`.
- Sequence 0x1D, 0x1D, 0xF0, 0x1D → exactly one `key_event`; `keys` returns to 0x0000 after the break.
- 0xE0 0x75 followed by 0x22 → the extended code has no effect; the 0x22 make sets `keys`=0x0001, `key_last`=0.
- Frame 0x16 with the parity bit inverted → with the macro defined: `frame_err` pulse, `keys` unchanged. Undefined: `keys`=0x0002.
- Start bit plus 3 data bits, then silence for `TIMEOUT_CYCLES` → one `frame_err`, FSM back in IDLE; a following valid 0x2A frame sets `keys`=0x8000.
- `reset` asserted mid-frame while `keys`=0x0011 → the next cycle shows all outputs 0; a subsequent valid frame decodes normally.
